hififo_tpc_writer: RTL and testbench

- Parametrised to-PC DMA write engine: splits a host buffer request (address, length in 8-byte words) into PCIe Memory Write TLPs.
- TLP payload is bounded by MAX_PAYLOAD_QW, the remaining count and the 4 KB address boundary.
- Reads payload from a single-clock first-word-fall-through FIFO with a level output. Emits header and data beats on a per-beat valid/ready stream to the PCIe TX arbiter.
- Supports 32- and 64-bit addressing, a per-request completion pulse, and a byte counter for status.

---
 rtl/hififo_tpc_writer.sv | 189 ++++++++++++++++++
 tb/tb_hififo_tpc_writer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hififo_tpc_writer.sv
// hififo_tpc_writer: to-PC DMA write engine.
// Splits a host buffer request into PCIe Memory Write TLPs. Each TLP payload is
// bounded by MAX_PAYLOAD_QW, the words still owed, and the 4 KB page boundary.
// Payload words come from a first-word-fall-through FIFO and leave as header
// and data beats on a valid/ready stream.
module hififo_tpc_writer #(
    parameter int MAX_PAYLOAD_QW = 16,
    parameter int LEVEL_W        = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [15:0]        pci_id,
    output logic [31:0]        status,
    input  logic               r_valid,
    input  logic [60:0]        r_addr,
    input  logic [18:0]        r_count,
    output logic               r_ready,
    output logic               r_done,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [63:0]        wr_data,
    output logic               wr_last,
    output logic               wr_half,
    input  logic [63:0]        i_data,
    input  logic [LEVEL_W-1:0] i_level,
    output logic               i_read
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_H0, S_H1, S_DATA} state_t;

    state_t      r_state;
    logic [60:0] r_cur_addr;      // next TLP address, 8-byte units
    logic [18:0] r_cur_count;     // words still to send
    logic [18:0] r_beat;          // data beat index within the TLP
    logic [31:0] r_hold;          // upper half of the previous word (32-bit mode)
    logic [31:0] r_status;
    logic        r_done_pulse;
    logic        r_wr_valid;
    logic        r_wr_last;
    logic        r_wr_half;

    logic [9:0]  w_room;
    logic [18:0] w_lim;
    logic [18:0] w_n;
    logic [18:0] w_last_idx;
    logic [9:0]  w_len_dw;
    logic        w_is64;
    logic [63:0] w_byte_addr;
    logic        w_accept;
    logic        w_level_ok;
    logic [63:0] w_hdr0;
    logic [63:0] w_wr_data;

    // Byte swap within a 32-bit lane.
    function automatic logic [31:0] es(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Payload size: the smallest of max payload, remaining words and room left in the 4 KB page.
    // Address and count only change at the end of a TLP, so n is stable for the whole packet.
    assign w_room      = 10'd512 - {1'b0, r_cur_addr[8:0]};
    assign w_lim       = (r_cur_count < 19'(MAX_PAYLOAD_QW)) ? r_cur_count : 19'(MAX_PAYLOAD_QW);
    assign w_n         = (w_lim < {9'd0, w_room}) ? w_lim : {9'd0, w_room};
    assign w_last_idx  = w_n - 19'd1;
    assign w_len_dw    = {w_n[8:0], 1'b0};
    assign w_is64      = |r_cur_addr[60:29];
    assign w_byte_addr = {r_cur_addr, 3'b000};
    assign w_accept    = r_wr_valid && wr_ready;
    assign w_level_ok  = 32'(i_level) >= 32'(w_n);
    assign w_hdr0      = {pci_id, 8'h00, 8'hFF, 2'b01, w_is64, 19'd0, w_len_dw};

    // Beat payload is formed from the FIFO head, which only moves on a pop,
    // so the beat holds steady while the arbiter stalls.
    always_comb begin
        w_wr_data = '0;
        case (r_state)
            S_H0: w_wr_data = w_hdr0;
            S_H1: begin
                if (w_is64)
                    w_wr_data = {w_byte_addr[31:0], w_byte_addr[63:32]};
                else
                    w_wr_data = {es(i_data[31:0]), w_byte_addr[31:0]};
            end
            S_DATA: begin
                if (w_is64)
                    w_wr_data = {es(i_data[63:32]), es(i_data[31:0])};
                else if (r_beat == w_last_idx)
                    w_wr_data = {32'h0, es(r_hold)};
                else
                    w_wr_data = {es(i_data[31:0]), es(r_hold)};
            end
            default: w_wr_data = '0;
        endcase
    end

    // Pop on every accepted beat that consumes a FIFO word: H1 in 32-bit mode,
    // every data beat in 64-bit mode, all but the trailing half beat in 32-bit mode.
    assign i_read = w_accept &&
                    ((r_state == S_H1 && !w_is64) ||
                     (r_state == S_DATA && (w_is64 || r_beat != w_last_idx)));

    // Request intake, packet sequencing and registered stream controls.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cur_addr   <= '0;
            r_cur_count  <= '0;
            r_beat       <= '0;
            r_hold       <= '0;
            r_status     <= '0;
            r_done_pulse <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_last    <= 1'b0;
            r_wr_half    <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            if (i_read)
                r_status <= r_status + 32'd8;
            if (r_valid && r_ready) begin
                r_cur_addr  <= r_addr;
                r_cur_count <= r_count;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_cur_count != 19'd0)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Wait for the whole payload so the packet never starves mid-stream.
                    if (w_level_ok) begin
                        r_state    <= S_H0;
                        r_wr_valid <= 1'b1;
                    end
                end
                S_H0: begin
                    if (w_accept)
                        r_state <= S_H1;
                end
                S_H1: begin
                    if (w_accept) begin
                        r_state <= S_DATA;
                        r_beat  <= '0;
                        if (!w_is64)
                            r_hold <= i_data[63:32];
                        if (w_n == 19'd1) begin
                            r_wr_last <= 1'b1;
                            r_wr_half <= !w_is64;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        if (r_beat == w_last_idx) begin
                            r_wr_valid  <= 1'b0;
                            r_wr_last   <= 1'b0;
                            r_wr_half   <= 1'b0;
                            r_cur_addr  <= r_cur_addr + 61'(w_n);
                            r_cur_count <= r_cur_count - w_n;
                            if (r_cur_count == w_n) begin
                                r_state      <= S_IDLE;
                                r_done_pulse <= 1'b1;
                            end else begin
                                r_state <= S_WAIT;
                            end
                        end else begin
                            r_beat <= r_beat + 19'd1;
                            if (!w_is64)
                                r_hold <= i_data[63:32];
                            if (r_beat + 19'd1 == w_last_idx) begin
                                r_wr_last <= 1'b1;
                                r_wr_half <= !w_is64;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign r_ready  = (r_state == S_IDLE) && (r_cur_count == 19'd0);
    assign r_done   = r_done_pulse;
    assign status   = r_status;
    assign wr_valid = r_wr_valid;
    assign wr_last  = r_wr_last;
    assign wr_half  = r_wr_half;
    assign wr_data  = w_wr_data;

endmodule

// File: tb/tb_hififo_tpc_writer.sv
// Bench for hififo_tpc_writer: table of requests plus hand-written starvation
// and mid-packet reset sequences; expected beats come from a TLP model.
module tb_hififo_tpc_writer;

    localparam int MAXP = 16;
    localparam int LW   = 10;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic [15:0]   pci_id   = 16'hBEEF;
    logic [31:0]   status;
    logic          r_valid  = 1'b0;
    logic [60:0]   r_addr   = '0;
    logic [18:0]   r_count  = '0;
    logic          r_ready;
    logic          r_done;
    logic          wr_valid;
    logic          wr_ready = 1'b1;
    logic [63:0]   wr_data;
    logic          wr_last;
    logic          wr_half;
    logic [63:0]   i_data   = '0;
    logic [LW-1:0] i_level  = '0;
    logic          i_read;

    hififo_tpc_writer #(.MAX_PAYLOAD_QW(MAXP), .LEVEL_W(LW)) dut (
        .clock(clock), .reset(reset), .pci_id(pci_id), .status(status),
        .r_valid(r_valid), .r_addr(r_addr), .r_count(r_count),
        .r_ready(r_ready), .r_done(r_done),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_last(wr_last), .wr_half(wr_half),
        .i_data(i_data), .i_level(i_level), .i_read(i_read)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        half;
    } beat_t;

    typedef struct {
        logic [60:0] addr;
        int          count;
        int          tlps;
        int          beats;
        bit          rnd;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    logic [63:0] fifo[$];
    logic [63:0] gen[$];
    int          beats, tlps, dones, pops;
    bit          mon_en = 1'b0;
    bit          rnd_ready = 1'b0;
    bit          any_valid;
    logic        held_valid = 1'b0;
    logic [63:0] held_data;
    logic        s_valid, s_ready, s_done, s_last, s_half, s_read;
    logic [31:0] s_status;
    int unsigned status_exp = 0;

    function automatic logic [31:0] es(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic update_fifo();
        i_data  = (fifo.size() != 0) ? fifo[0] : 64'h0;
        i_level = LW'(fifo.size());
    endtask

    // One clock: sample/compare at negedge, apply FIFO pop and new ready after posedge.
    task automatic tick();
        beat_t e;
        @(negedge clock);
        s_valid  = wr_valid;
        s_ready  = r_ready;
        s_done   = r_done;
        s_last   = wr_last;
        s_half   = wr_half;
        s_read   = i_read;
        s_status = status;
        if (wr_valid) any_valid = 1'b1;
        if (mon_en) begin
            if (held_valid && wr_valid)
                check("hold_data", wr_data, held_data);
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h required no beat", wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", wr_data, e.data);
                    check("beat_last", 64'(wr_last), 64'(e.last));
                    check("beat_half", 64'(wr_half), 64'(e.half));
                    $display("beat %0d data=%h last=%0b half=%0b", beats, wr_data, wr_last, wr_half);
                end
                beats++;
                if (wr_last) tlps++;
            end
            if (i_read)
                check("pop_on_accept", 64'(wr_valid && wr_ready), 64'd1);
            if (r_done) begin
                dones++;
                check("done_ready", 64'(r_ready), 64'd1);
            end
        end
        held_valid = wr_valid && !wr_ready;
        held_data  = wr_data;
        if (s_read) pops++;
        @(posedge clock);
        #1;
        if (s_read && fifo.size() != 0) void'(fifo.pop_front());
        update_fifo();
        wr_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    // Reference TLP model: builds the expected beat sequence for a request.
    task automatic prep(input logic [60:0] addr, input int count);
        logic [60:0] a;
        logic [63:0] ba, w, wp;
        logic [9:0]  len;
        logic        is64;
        int          c, n, room, wi;
        gen.delete();
        exp_q.delete();
        for (int i = 0; i < count; i++) gen.push_back({$urandom, $urandom});
        a = addr; c = count; wi = 0;
        while (c > 0) begin
            room = 512 - int'(a[8:0]);
            n = MAXP;
            if (c < n) n = c;
            if (room < n) n = room;
            is64 = (a[60:29] != 0);
            ba   = {a, 3'b000};
            len  = 10'(2 * n);
            exp_q.push_back('{{pci_id, 8'h00, 8'hFF, 2'b01, is64, 19'd0, len}, 1'b0, 1'b0});
            if (is64) begin
                exp_q.push_back('{{ba[31:0], ba[63:32]}, 1'b0, 1'b0});
                for (int k = 0; k < n; k++) begin
                    w = gen[wi + k];
                    exp_q.push_back('{{es(w[63:32]), es(w[31:0])}, (k == n - 1), 1'b0});
                end
            end else begin
                w = gen[wi];
                exp_q.push_back('{{es(w[31:0]), ba[31:0]}, 1'b0, 1'b0});
                for (int k = 1; k < n; k++) begin
                    w  = gen[wi + k];
                    wp = gen[wi + k - 1];
                    exp_q.push_back('{{es(w[31:0]), es(wp[63:32])}, 1'b0, 1'b0});
                end
                wp = gen[wi + n - 1];
                exp_q.push_back('{{32'h0, es(wp[63:32])}, 1'b1, 1'b1});
            end
            wi += n; a += 61'(n); c -= n;
        end
    endtask

    task automatic clear_counts();
        beats = 0; tlps = 0; dones = 0; pops = 0;
    endtask

    task automatic request(input logic [60:0] a, input int c);
        int b = 0;
        while (!r_ready && b < 100) begin tick(); b++; end
        check("req_ready", 64'(r_ready), 64'd1);
        r_valid = 1'b1; r_addr = a; r_count = 19'(c);
        tick();
        r_valid = 1'b0;
    endtask

    task automatic finish_req(input int count, input int e_tlps, input int e_beats, input int e_dones);
        int budget = 0;
        while ((exp_q.size() != 0 || dones < e_dones) && budget < 3000) begin
            tick(); budget++;
        end
        check("timeout", 64'(budget < 3000), 64'd1);
        repeat (4) tick();
        check("tlps", 64'(tlps), 64'(e_tlps));
        check("beats", 64'(beats), 64'(e_beats));
        check("dones", 64'(dones), 64'(e_dones));
        check("pops", 64'(pops), 64'(count));
        check("status", 64'(s_status), 64'(status_exp));
        check("idle_ready", 64'(r_ready), 64'd1);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{61'h2000_0000,   16, 1, 18, 1'b0};
        vecs[1] = '{61'h200,         40, 3, 46, 1'b0};
        vecs[2] = '{61'h1FE,          4, 2,  8, 1'b0};
        vecs[3] = '{61'h0,            0, 0,  0, 1'b0};
        vecs[4] = '{61'h7FF,          5, 2,  9, 1'b1};
        vecs[5] = '{61'h3000_01FF,    3, 2,  7, 1'b1};
        vecs[6] = '{61'h123,         20, 2, 24, 1'b1};
        vecs[7] = '{61'h1_0000_0010, 33, 3, 39, 1'b1};
        vecs[8] = '{61'h40,          17, 2, 21, 1'b1};

        // Power-on reset values
        repeat (3) tick();
        check("rst_wr_valid", 64'(s_valid), 64'd0);
        check("rst_wr_last", 64'(s_last), 64'd0);
        check("rst_wr_half", 64'(s_half), 64'd0);
        check("rst_r_done", 64'(s_done), 64'd0);
        check("rst_status", 64'(s_status), 64'd0);
        check("rst_r_ready", 64'(s_ready), 64'd1);
        check("rst_i_read", 64'(s_read), 64'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // Table-driven requests
        for (int i = 0; i < 9; i++) begin
            rnd_ready = vecs[i].rnd;
            clear_counts();
            prep(vecs[i].addr, vecs[i].count);
            foreach (gen[j]) fifo.push_back(gen[j]);
            update_fifo();
            request(vecs[i].addr, vecs[i].count);
            status_exp += 32'(8 * vecs[i].count);
            finish_req(vecs[i].count, vecs[i].tlps, vecs[i].beats, (vecs[i].count != 0) ? 1 : 0);
            $display("vector %0d addr=%h count=%0d tlps=%0d beats=%0d", i, vecs[i].addr, vecs[i].count, tlps, beats);
        end

        // Starvation: level 5 below n=8, busy request ignored, then level 8 releases H0
        rnd_ready = 1'b1;
        clear_counts();
        prep(61'h400, 8);
        for (int j = 0; j < 5; j++) fifo.push_back(gen[j]);
        update_fifo();
        request(61'h400, 8);
        any_valid = 1'b0;
        repeat (3) tick();
        check("busy_not_ready", 64'(r_ready), 64'd0);
        r_valid = 1'b1; r_addr = 61'h40; r_count = 19'd7;
        tick();
        r_valid = 1'b0;
        repeat (6) tick();
        check("starve_no_valid", 64'(any_valid), 64'd0);
        for (int j = 5; j < 8; j++) fifo.push_back(gen[j]);
        update_fifo();
        tick();
        check("starve_wait", 64'(s_valid), 64'd0);
        tick();
        check("starve_h0", 64'(s_valid), 64'd1);
        status_exp += 32'd64;
        finish_req(8, 1, 10, 1);

        // Reset during the third data beat
        rnd_ready = 1'b0;
        clear_counts();
        prep(61'h2000_0000, 16);
        foreach (gen[j]) fifo.push_back(gen[j]);
        update_fifo();
        request(61'h2000_0000, 16);
        for (int b = 0; b < 100 && beats < 4; b++) tick();
        check("pre_reset_beats", 64'(beats), 64'd4);
        reset = 1'b1;
        mon_en = 1'b0;
        tick();
        fifo.delete();
        update_fifo();
        tick();
        check("abort_wr_valid", 64'(s_valid), 64'd0);
        check("abort_r_ready", 64'(s_ready), 64'd1);
        check("abort_status", 64'(s_status), 64'd0);
        check("abort_r_done", 64'(s_done), 64'd0);
        check("abort_wr_last", 64'(s_last), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        held_valid = 1'b0;
        status_exp = 0;
        tick();
        mon_en = 1'b1;

        // Recovery after abort
        clear_counts();
        prep(61'h10, 2);
        foreach (gen[j]) fifo.push_back(gen[j]);
        update_fifo();
        request(61'h10, 2);
        status_exp += 32'd16;
        finish_req(2, 1, 4, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

endmodule
